dac_wave_gen: RTL and testbench

DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

---
 rtl/dac_wave_gen.sv | 197 +++++++++++++++++++
 tb/tb_dac_wave_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen.sv
// DAC waveform generator: constant/ramp/triangle/square codes on a valid/ready link.
// Triangle mode is built only with DAC_WAVE_TRI_EN defined; otherwise mode 2 is a ramp.
module dac_wave_gen #(
  parameter int DATA_W = 12,
  parameter int DIV_W  = 16
) (
  input  logic              clk_X4,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] step,
  input  logic [DIV_W-1:0]  period,
  input  logic              data_ready,
  input  logic              clr_underrun,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              underrun
);

  localparam logic [1:0] M_CONST = 2'd0;
  localparam logic [1:0] M_TRI   = 2'd2;
  localparam logic [1:0] M_SQ    = 2'd3;

  localparam logic [DATA_W-1:0] CODE_MAX = '1;
  localparam logic [DATA_W-1:0] CODE_MIN = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] gen_q, gen_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              unf_q, unf_d;

  logic              tick;
  logic              xfer;
  logic [DATA_W-1:0] first_code;
  logic [DATA_W-1:0] nxt_code;

`ifdef DAC_WAVE_TRI_EN
  logic              dir_q, dir_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_eff;
  logic              nxt_dir;
  logic [DATA_W:0]   sum_w;
`endif

  assign tick = (state_q != IDLE) && (cnt_q == period);
  assign xfer = valid_q && data_ready;

  assign first_code = (mode == M_CONST) ? step : CODE_MIN;

  // Next generator code for the current mode, advanced from gen_q.
  always_comb begin
    nxt_code = gen_q + step;
`ifdef DAC_WAVE_TRI_EN
    sum_w   = {1'b0, gen_q} + {1'b0, step};
    dir_eff = (mode_q != mode) ? 1'b0 : dir_q;
    nxt_dir = 1'b0;
`endif
    unique case (1'b1)
      (mode == M_CONST): begin
        nxt_code = step;
      end
      (mode == M_SQ): begin
        nxt_code = (gen_q == CODE_MIN) ? CODE_MAX : CODE_MIN;
      end
`ifdef DAC_WAVE_TRI_EN
      (mode == M_TRI): begin
        nxt_dir = dir_eff;
        if (!dir_eff) begin
          if (sum_w >= {1'b0, CODE_MAX}) begin
            nxt_code = CODE_MAX;
            nxt_dir  = 1'b1;
          end else begin
            nxt_code = sum_w[DATA_W-1:0];
          end
        end else begin
          if (gen_q <= step) begin
            nxt_code = CODE_MIN;
            nxt_dir  = 1'b0;
          end else begin
            nxt_code = gen_q - step;
          end
        end
      end
`endif
      default: begin
        nxt_code = gen_q + step;
      end
    endcase
  end

  // Handshake FSM, sample-interval counter and underrun bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gen_d   = gen_q;
    data_d  = data_q;
    valid_d = valid_q;
    unf_d   = clr_underrun ? 1'b0 : unf_q;
`ifdef DAC_WAVE_TRI_EN
    dir_d   = dir_q;
    mode_d  = mode_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      gen_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
`ifdef DAC_WAVE_TRI_EN
      dir_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = PEND;
          cnt_d   = '0;
          gen_d   = first_code;
          data_d  = first_code;
          valid_d = 1'b1;
`ifdef DAC_WAVE_TRI_EN
          dir_d   = 1'b0;
          mode_d  = mode;
`endif
        end
        RUN, PEND: begin
          cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
          if (tick) begin
            gen_d  = nxt_code;
`ifdef DAC_WAVE_TRI_EN
            dir_d  = nxt_dir;
            mode_d = mode;
`endif
          end
          if (tick && ((state_q == RUN) || xfer)) begin
            data_d  = nxt_code;
            valid_d = 1'b1;
            state_d = PEND;
          end else if (tick) begin
            // Sample dropped: the held code stays, generator moves on.
            unf_d = 1'b1;
          end else if (xfer) begin
            valid_d = 1'b0;
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers, all on the falling edge of clk_X4.
  always_ff @(negedge clk_X4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gen_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gen_q   <= gen_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      unf_q   <= unf_d;
    end
  end

`ifdef DAC_WAVE_TRI_EN
  // Triangle direction and the mode last applied at a tick.
  always_ff @(negedge clk_X4 or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= 1'b0;
      mode_q <= 2'd0;
    end else begin
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end
`endif

  assign data       = data_q;
  assign data_valid = valid_q;
  assign underrun   = unf_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed table-driven bench for dac_wave_gen.
// Inputs change on posedge, DUT acts on negedge, outputs sampled on posedge.
module tb_dac_wave_gen;

  logic        clk_X4 = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] step;
  logic [15:0] period;
  logic        data_ready;
  logic        clr_underrun;
  logic [11:0] data;
  logic        data_valid;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [1:0]  md;
    logic [11:0] st;
    logic [15:0] per;
    logic        rdy;
    logic        clr;
    int          adv;
    logic [11:0] d;
    logic        v;
    logic        u;
  } vec_t;

  vec_t tv[$];

  always #5 clk_X4 = ~clk_X4;

  dac_wave_gen dut (
    .clk_X4      (clk_X4),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .step        (step),
    .period      (period),
    .data_ready  (data_ready),
    .clr_underrun(clr_underrun),
    .data        (data),
    .data_valid  (data_valid),
    .underrun    (underrun)
  );

  task automatic add(input int en, input int md, input int st,
                     input int per, input int rdy, input int clr,
                     input int adv, input int d, input int v,
                     input int u);
    vec_t r;
    r.en  = en[0];
    r.md  = md[1:0];
    r.st  = st[11:0];
    r.per = per[15:0];
    r.rdy = rdy[0];
    r.clr = clr[0];
    r.adv = adv;
    r.d   = d[11:0];
    r.v   = v[0];
    r.u   = u[0];
    tv.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [11:0] d,
                     input logic v, input logic u);
    checks++;
    if (data !== d || data_valid !== v || underrun !== u) begin
      errors++;
      $display("FAIL %s: got data=%0d valid=%0b underrun=%0b, want data=%0d valid=%0b underrun=%0b",
               nm, data, data_valid, underrun, d, v, u);
    end
  endtask

  initial begin
    int tri_exp[12];
`ifdef DAC_WAVE_TRI_EN
    tri_exp = '{0, 1000, 2000, 3000, 4000, 4095,
                3095, 2095, 1095, 95, 0, 1000};
`else
    tri_exp = '{0, 1000, 2000, 3000, 4000, 904,
                1904, 2904, 3904, 808, 1808, 2808};
`endif

    // Ramp, step 256, one sample per 100 cycles, sink always ready.
    add(1, 1, 256, 99, 1, 0, 1, 0, 1, 0);
    add(1, 1, 256, 99, 1, 0, 1, 0, 0, 0);
    add(1, 1, 256, 99, 1, 0, 98, 0, 0, 0);
    add(1, 1, 256, 99, 1, 0, 1, 256, 1, 0);
    for (int k = 2; k <= 16; k++)
      add(1, 1, 256, 99, 1, 0, 100, (k * 256) % 4096, 1, 0);
    add(0, 1, 256, 99, 1, 0, 1, 0, 0, 0);

    // Constant level.
    add(1, 0, 77, 0, 1, 0, 1, 77, 1, 0);
    add(1, 0, 77, 0, 1, 0, 2, 77, 1, 0);
    add(0, 0, 77, 0, 1, 0, 1, 0, 0, 0);

    // Square alternates starting at 0.
    add(1, 3, 5, 0, 1, 0, 1, 0, 1, 0);
    add(1, 3, 5, 0, 1, 0, 1, 4095, 1, 0);
    add(1, 3, 5, 0, 1, 0, 1, 0, 1, 0);
    add(1, 3, 5, 0, 1, 0, 1, 4095, 1, 0);
    add(0, 3, 5, 0, 1, 0, 1, 0, 0, 0);

    // Ramp with step 0 holds.
    add(1, 1, 0, 0, 1, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 3, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);

    // Mode 2, tick and transfer on every edge.
    for (int k = 0; k < 12; k++)
      add(1, 2, 1000, 0, 1, 0, 1, tri_exp[k], 1, 0);
    add(0, 2, 1000, 0, 1, 0, 1, 0, 0, 0);

    // Stalled sink: sample dropped, then transfer and next code 3.
    add(1, 1, 1, 3, 0, 0, 1, 0, 1, 0);
    add(1, 1, 1, 3, 0, 0, 3, 0, 1, 0);
    add(1, 1, 1, 3, 0, 0, 1, 0, 1, 1);
    add(1, 1, 1, 3, 0, 0, 6, 0, 1, 1);
    add(1, 1, 1, 3, 1, 0, 1, 0, 0, 1);
    add(1, 1, 1, 3, 1, 0, 1, 3, 1, 1);
    add(1, 1, 1, 3, 0, 1, 1, 3, 1, 0);
    add(1, 1, 1, 3, 0, 1, 3, 3, 1, 1);

    // Enable drop mid-ramp keeps underrun.
    add(0, 1, 256, 0, 1, 0, 1, 0, 0, 1);
    add(1, 1, 256, 0, 1, 0, 1, 0, 1, 1);
    add(1, 1, 256, 0, 1, 0, 6, 1536, 1, 1);
    add(0, 1, 256, 0, 1, 0, 1, 0, 0, 1);
    add(1, 1, 256, 0, 1, 0, 1, 0, 1, 1);
    add(0, 1, 256, 0, 1, 1, 1, 0, 0, 0);

    rst_n        = 1'b0;
    enable       = 1'b0;
    mode         = 2'd0;
    step         = 12'd0;
    period       = 16'd0;
    data_ready   = 1'b0;
    clr_underrun = 1'b0;

    repeat (2) @(posedge clk_X4);
    chk("reset", 12'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      enable       = tv[i].en;
      mode         = tv[i].md;
      step         = tv[i].st;
      period       = tv[i].per;
      data_ready   = tv[i].rdy;
      clr_underrun = tv[i].clr;
      repeat (tv[i].adv) @(negedge clk_X4);
      @(posedge clk_X4);
      chk($sformatf("vec%0d", i), tv[i].d, tv[i].v, tv[i].u);
    end

    // Asynchronous reset between edges while a code is pending.
    enable       = 1'b1;
    mode         = 2'd0;
    step         = 12'd1234;
    period       = 16'd9;
    data_ready   = 1'b0;
    clr_underrun = 1'b0;
    @(negedge clk_X4);
    @(posedge clk_X4);
    chk("pend_before_rst", 12'd1234, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 12'd0, 1'b0, 1'b0);
    @(posedge clk_X4);
    chk("rst_held", 12'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk_X4);
    @(posedge clk_X4);
    chk("after_rst", 12'd1234, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
